mii_stream_tx_gen: RTL and testbench
====================================

// Module: mii_stream_tx_gen
// PURPOSE
//  Parametrised XGMII/XLGMII-style TX framer. Accepts a payload beat stream over valid/ready,
//  emits Start+preamble+SFD, payload, optional FCS, Terminate and IPG idles as lane data/ctrl.
//  Generalises the fixed 64-bit MAC->MII path to 4- or 8-lane buses, adds underrun signalling
//  and frame/underrun counters. Sits between the MAC frame source and the PCS encoder.
// PARAMETERS
//  LANES      8    byte lanes per beat; legal 4 or 8 (else elaboration $error)
//  IPG_BYTES  12   minimum idle bytes after Terminate, rounded up to whole beats
//  CNT_W      32   width of o_frame_cnt
// PORTS
//  clk            in   1         clock
//  i_rst_n        in   1         async reset, active low
//  i_s_valid      in   1         payload beat valid
//  i_s_data       in   LANES*8   payload, lane 0 = bits[7:0] = first byte on wire
//  i_s_last       in   1         last beat of frame
//  i_s_nbytes     in   clog2(LANES)+1  valid bytes on last beat (1..LANES); ignored otherwise
//  o_s_ready      out  1         beat accepted when i_s_valid && o_s_ready
//  o_mii_data     out  LANES*8   lane data
//  o_mii_ctrl     out  LANES     per-lane control flag (1 = control char)
//  o_busy         out  1         high from Start beat through last IPG beat
//  o_frame_cnt    out  CNT_W     frames completed (Terminate emitted), wraps
//  o_underrun_cnt out  16        aborted frames, saturates at 16'hFFFF
// BEHAVIOUR
//  Chars: IDLE 8'h07, START 8'hFB (lane 0 only), PRE 8'h55, SFD 8'hD5, TERM 8'hFD, ERR 8'hFE.
//  Reset (async): data all 8'h07, ctrl all 1, ready 0, busy 0, counters 0, FSM IDLE.
//   Reset mid-frame: outputs idle immediately, partial frame dropped, not counted.
//  All outputs registered; first output char appears 1 clk after the accepting edge.
//  FSM IDLE -> PRE -> DATA -> (TAIL) -> IPG -> IDLE:
//   IDLE: emit idles; on i_s_valid go PRE (beat not consumed; ready 0).
//   PRE: LANES=8: one beat FB 55 55 55 55 55 55 D5, ctrl 8'h01.
//        LANES=4: FB 55 55 55 ctrl 4'h1, then 55 55 55 D5 ctrl 4'h0.
//   DATA: ready 1; each accepted beat emitted as data, ctrl 0.
//    Last beat with n<LANES: bytes 0..n-1 data, lane n TERM, lanes above IDLE (ctrl 1) -> IPG.
//    Last beat with n==LANES: full data; TAIL emits TERM in lane 0 + idles -> IPG.
//    Underrun (i_s_valid low in DATA): emit one beat all ERR, ctrl all 1; frame aborted;
//     remaining beats drained (ready 1, outputs idle) up to and incl. i_s_last, then IPG;
//     o_underrun_cnt++, o_frame_cnt unchanged; no TERM emitted for aborted frame.
//   IPG: idle beats until idle bytes since TERM >= IPG_BYTES (idle lanes in TERM beat count);
//    ready 0 throughout; next Start only after IPG done. i_s_valid waiting in IPG is held.
//  o_frame_cnt increments on the clk the TERM beat is driven.
//  i_s_nbytes 0 or >LANES on last beat: treated as LANES.
// CONFIGURATION
//  MII_TX_FCS_EN defined: CRC-32 (poly 04C11DB7, init FFFFFFFF, reflected, final inverted)
//   over all payload bytes; 4 FCS bytes appended LSB-first right after last payload byte,
//   spilling into TAIL beat as needed; TERM follows FCS. ready held 0 during spill.
//   Aborted frames carry no FCS.
//  Undefined: no CRC logic; TERM directly after last payload byte as above.
// TESTING
//  1 LANES=8, 8-beat frame of 8'hAA, nbytes=8 -> FB55..D5/01, 8 data beats ctrl 00,
//    TAIL FD070707_07070707 ctrl FF, >=1 idle beat, o_frame_cnt=1.
//  2 LANES=8, 1 beat nbytes=3 -> beat: 3 data, lane3 FD, ctrl 8'hF8; IPG 12 bytes:
//    4 idles in TERM beat + 1 idle beat before next Start.
//  3 LANES=4, 2-beat frame nbytes=4 -> 2 preamble beats ctrl 1/0, data, TERM beat ctrl F,
//    IPG 3 beats; back-to-back frame starts on cycle after IPG.
//  4 Drop i_s_valid on 3rd data beat -> one all-FE beat ctrl FF, drain to last,
//    o_underrun_cnt=1, o_frame_cnt unchanged, no FD seen.
//  5 Assert i_rst_n=0 during DATA -> same-cycle idles/ctrl all 1, counters 0, ready 0.
//  6 MII_TX_FCS_EN, LANES=8, 60-byte known frame (nbytes=4 last) -> FCS bytes match
//    reference CRC in lanes 4..7, TERM lane 0 of next beat.

Source files
------------

// File: rtl/mii_stream_tx_gen.sv
// mii_stream_tx_gen: XGMII/XLGMII-style TX framer for 4 or 8 byte lanes, with underrun abort and frame counters.
// Define MII_TX_FCS_EN to append a CRC-32 FCS after the payload; the default build has no CRC logic.
module mii_stream_tx_gen #(
    parameter int LANES     = 8,
    parameter int IPG_BYTES = 12,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_s_valid,
    input  logic [LANES*8-1:0]       i_s_data,
    input  logic                     i_s_last,
    input  logic [$clog2(LANES):0]   i_s_nbytes,
    output logic                     o_s_ready,
    output logic [LANES*8-1:0]       o_mii_data,
    output logic [LANES-1:0]         o_mii_ctrl,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_frame_cnt,
    output logic [15:0]              o_underrun_cnt
);
    // state    | meaning
    // ST_IDLE  | idles out; a waiting beat launches the Start beat
    // ST_PRE   | second preamble beat (4-lane bus only)
    // ST_DATA  | ready high; each accepted beat is emitted, missing beat aborts
    // ST_TAIL  | FCS spill and/or Terminate after a full last beat
    // ST_DRAIN | aborted frame: swallow beats up to i_s_last, emit idles
    // ST_IPG   | idles until enough idle bytes follow Terminate

    localparam int ACC_W = $clog2(IPG_BYTES + 2*LANES + 1) + 1;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;

`ifdef MII_TX_FCS_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif

    if (LANES != 4 && LANES != 8) begin : g_bad_lanes
        $error("mii_stream_tx_gen: LANES must be 4 or 8");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_TAIL,
        ST_DRAIN,
        ST_IPG
    } state_t;

    state_t             state;
    logic [2:0]         fcs_left;
    logic [31:0]        fcs_rem;
    logic [ACC_W-1:0]   idle_acc;

    logic [31:0]        fcs_word;
    logic [7:0]         fcs_b [4];
    logic [7:0]         rem_b [4];
    logic [LANES*8-1:0] pre0_data, pre1_data, last_data, tail_data;
    logic [LANES-1:0]   last_ctrl, tail_ctrl;
    int                 n_eff, last_idle, tail_idle;
    logic               last_done, tail_done, ipg_done;
    logic [2:0]         last_spill;
    logic [31:0]        spill_rem;

    // Out-of-range byte counts on the last beat mean a full beat.
    always_comb begin
        n_eff = LANES;
        if (i_s_nbytes != '0 && int'(i_s_nbytes) <= LANES)
            n_eff = int'(i_s_nbytes);
    end

`ifdef MII_TX_FCS_EN
    logic [31:0] crc_reg, crc_full, crc_last;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_full = crc_reg;
        crc_last = crc_reg;
        for (int i = 0; i < LANES; i++) begin
            crc_full = crc_byte(crc_full, i_s_data[8*i +: 8]);
            if (i < n_eff)
                crc_last = crc_byte(crc_last, i_s_data[8*i +: 8]);
        end
    end

    assign fcs_word = ~crc_last;

    // Running CRC only lives inside DATA; any other state re-seeds it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            crc_reg <= '1;
        else if (state == ST_DATA && i_s_valid && !i_s_last)
            crc_reg <= crc_full;
        else if (state != ST_DATA)
            crc_reg <= '1;
    end
`else
    assign fcs_word = '0;
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fcs_b[k] = fcs_word[8*k +: 8];
            rem_b[k] = fcs_rem[8*k +: 8];
        end
    end

    // Beat images: preamble, last payload beat (data|FCS|TERM|idles) and tail beat (FCS spill|TERM|idles).
    always_comb begin
        pre0_data = '0;
        pre1_data = '0;
        last_data = '0;
        last_ctrl = '0;
        tail_data = '0;
        tail_ctrl = '0;
        for (int i = 0; i < LANES; i++) begin
            pre0_data[8*i +: 8] = (i == 0) ? C_START :
                                  (LANES == 8 && i == LANES-1) ? C_SFD : C_PRE;
            pre1_data[8*i +: 8] = (i == LANES-1) ? C_SFD : C_PRE;

            if (i < n_eff) begin
                last_data[8*i +: 8] = i_s_data[8*i +: 8];
                last_ctrl[i]        = 1'b0;
            end else if (i < n_eff + FCS_BYTES) begin
                last_data[8*i +: 8] = fcs_b[2'(i - n_eff)];
                last_ctrl[i]        = 1'b0;
            end else if (i == n_eff + FCS_BYTES) begin
                last_data[8*i +: 8] = C_TERM;
                last_ctrl[i]        = 1'b1;
            end else begin
                last_data[8*i +: 8] = C_IDLE;
                last_ctrl[i]        = 1'b1;
            end

            if (i < int'(fcs_left)) begin
                tail_data[8*i +: 8] = rem_b[2'(i)];
                tail_ctrl[i]        = 1'b0;
            end else if (i == int'(fcs_left)) begin
                tail_data[8*i +: 8] = C_TERM;
                tail_ctrl[i]        = 1'b1;
            end else begin
                tail_data[8*i +: 8] = C_IDLE;
                tail_ctrl[i]        = 1'b1;
            end
        end
        last_done  = (n_eff + FCS_BYTES) < LANES;
        last_idle  = LANES - n_eff - FCS_BYTES - 1;
        last_spill = 3'(n_eff + FCS_BYTES - LANES);
        spill_rem  = fcs_word >> (8 * (LANES - n_eff));
        tail_done  = int'(fcs_left) < LANES;
        tail_idle  = LANES - 1 - int'(fcs_left);
        ipg_done   = idle_acc >= ACC_W'(IPG_BYTES);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            o_mii_data     <= {LANES{C_IDLE}};
            o_mii_ctrl     <= '1;
            o_s_ready      <= 1'b0;
            o_busy         <= 1'b0;
            o_frame_cnt    <= '0;
            o_underrun_cnt <= '0;
            fcs_left       <= '0;
            fcs_rem        <= '0;
            idle_acc       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_IPG: begin
                    if (state == ST_IPG && !ipg_done) begin
                        o_mii_data <= {LANES{C_IDLE}};
                        o_mii_ctrl <= '1;
                        idle_acc   <= idle_acc + ACC_W'(LANES);
                    end else if (i_s_valid) begin
                        o_mii_data <= pre0_data;
                        o_mii_ctrl <= LANES'(1);
                        o_busy     <= 1'b1;
                        if (LANES == 8) begin
                            o_s_ready <= 1'b1;
                            state     <= ST_DATA;
                        end else begin
                            state     <= ST_PRE;
                        end
                    end else begin
                        o_mii_data <= {LANES{C_IDLE}};
                        o_mii_ctrl <= '1;
                        o_busy     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_PRE: begin
                    o_mii_data <= pre1_data;
                    o_mii_ctrl <= '0;
                    o_s_ready  <= 1'b1;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    if (!i_s_valid) begin
                        o_mii_data <= {LANES{C_ERR}};
                        o_mii_ctrl <= '1;
                        if (o_underrun_cnt != 16'hFFFF)
                            o_underrun_cnt <= o_underrun_cnt + 16'd1;
                        state      <= ST_DRAIN;
                    end else if (!i_s_last) begin
                        o_mii_data <= i_s_data;
                        o_mii_ctrl <= '0;
                    end else begin
                        o_mii_data <= last_data;
                        o_mii_ctrl <= last_ctrl;
                        o_s_ready  <= 1'b0;
                        if (last_done) begin
                            o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                            idle_acc    <= ACC_W'(last_idle);
                            state       <= ST_IPG;
                        end else begin
                            fcs_left <= last_spill;
                            fcs_rem  <= spill_rem;
                            state    <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    o_mii_data <= tail_data;
                    o_mii_ctrl <= tail_ctrl;
                    if (tail_done) begin
                        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                        idle_acc    <= ACC_W'(tail_idle);
                        state       <= ST_IPG;
                    end else begin
                        fcs_left <= '0;
                    end
                end
                ST_DRAIN: begin
                    o_mii_data <= {LANES{C_IDLE}};
                    o_mii_ctrl <= '1;
                    if (i_s_valid && i_s_last) begin
                        o_s_ready <= 1'b0;
                        idle_acc  <= '0;
                        state     <= ST_IPG;
                    end
                end
                default: begin
                    o_mii_data <= {LANES{C_IDLE}};
                    o_mii_ctrl <= '1;
                    o_s_ready  <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_stream_tx_gen.sv
// Scoreboard bench for mii_stream_tx_gen: an 8-lane and a 4-lane instance, expected beats queued per frame.
// Expected beats assume the default build (MII_TX_FCS_EN undefined).
module tb_mii_stream_tx_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v8, l8, r8, b8;
    logic [63:0] d8, md8;
    logic [3:0]  nb8;
    logic [7:0]  mc8;
    logic [31:0] fc8;
    logic [15:0] uc8;
    logic        v4, l4, r4, b4;
    logic [31:0] d4, md4;
    logic [2:0]  nb4;
    logic [3:0]  mc4;
    logic [31:0] fc4;
    logic [15:0] uc4;

    mii_stream_tx_gen #(.LANES(8), .IPG_BYTES(12), .CNT_W(32)) u8 (
        .clk(clk), .i_rst_n(rst_n), .i_s_valid(v8), .i_s_data(d8), .i_s_last(l8),
        .i_s_nbytes(nb8), .o_s_ready(r8), .o_mii_data(md8), .o_mii_ctrl(mc8),
        .o_busy(b8), .o_frame_cnt(fc8), .o_underrun_cnt(uc8));

    mii_stream_tx_gen #(.LANES(4), .IPG_BYTES(12), .CNT_W(32)) u4 (
        .clk(clk), .i_rst_n(rst_n), .i_s_valid(v4), .i_s_data(d4), .i_s_last(l4),
        .i_s_nbytes(nb4), .o_s_ready(r4), .o_mii_data(md4), .o_mii_ctrl(mc4),
        .o_busy(b4), .o_frame_cnt(fc4), .o_underrun_cnt(uc4));

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        b;
    } beat_t;

    localparam logic [63:0] IDL8 = 64'h0707070707070707;
    localparam logic [63:0] PRE8 = 64'hD5555555555555FB;
    localparam logic [63:0] ERR8 = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] TRM8 = 64'h07070707070707FD;
    localparam logic [31:0] IDL4 = 32'h07070707;

    beat_t q8[$];
    beat_t q4[$];
    int    compared   = 0;
    int    mismatched = 0;
    bit    act8 = 1'b0;
    bit    act4 = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void p8(input logic [63:0] d, input logic [7:0] c, input logic b);
        q8.push_back({d, c, b});
    endfunction

    function automatic void p4(input logic [31:0] d, input logic [3:0] c, input logic b);
        q4.push_back({32'h0, d, 4'h0, c, b});
    endfunction

    // Monitors: lock onto a Start beat, then compare every beat while expectations remain queued.
    always @(negedge clk) begin : mon8
        beat_t e;
        if (q8.size() > 0 && (act8 || (md8[7:0] == 8'hFB && mc8[0]))) begin
            e = q8.pop_front();
            check("u8_beat", {7'b0, md8, mc8, b8}, {7'b0, e});
            act8 = q8.size() > 0;
        end
    end

    always @(negedge clk) begin : mon4
        beat_t e;
        if (q4.size() > 0 && (act4 || (md4[7:0] == 8'hFB && mc4[0]))) begin
            e = q4.pop_front();
            check("u4_beat", {7'b0, 32'h0, md4, 4'h0, mc4, b4}, {7'b0, e});
            act4 = q4.size() > 0;
        end
    end

    task automatic send(input bit is4, input logic [63:0] data, input bit last, input int nb);
        int budget;
        budget = 0;
        if (is4) begin
            v4 = 1'b1; d4 = data[31:0]; l4 = last; nb4 = 3'(nb);
        end else begin
            v8 = 1'b1; d8 = data; l8 = last; nb8 = 4'(nb);
        end
        forever begin
            @(negedge clk);
            if ((is4 ? r4 : r8) === 1'b1) break;
            budget++;
            if (budget > 100) begin
                compared++;
                mismatched++;
                $display("FAIL ready_timeout: waited %0d cycles, expected ready high", budget);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (is4) v4 = 1'b0; else v8 = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q8.size() > 0 || q4.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 80'(q8.size() + q4.size()), 80'd0);
        q8.delete();
        q4.delete();
        act8 = 1'b0;
        act4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v8 = 0; d8 = '0; l8 = 0; nb8 = '0;
        v4 = 0; d4 = '0; l4 = 0; nb4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data8",  80'(md8), 80'(IDL8));
        check("rst_ctrl8",  80'(mc8), 80'(8'hFF));
        check("rst_misc8",  80'({r8, b8, fc8, uc8}), 80'd0);
        check("rst_data4",  80'({mc4, md4}), 80'({4'hF, IDL4}));
        check("rst_misc4",  80'({r4, b4, fc4, uc4}), 80'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8 full beats of AA: preamble, data, TERM-only tail, one IPG idle.
        p8(PRE8, 8'h01, 1);
        for (int i = 0; i < 8; i++) p8({8{8'hAA}}, 8'h00, 1);
        p8(TRM8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 0);
        for (int i = 0; i < 8; i++) send(0, {8{8'hAA}}, i == 7, 8);
        wait_drain();
        check("t1_frame_cnt", 80'(fc8), 80'd1);

        // Two back-to-back single-beat frames, 3 bytes each: 4 idles in TERM beat + 1 idle beat.
        p8(PRE8, 8'h01, 1);
        p8(64'h07070707FD332211, 8'hF8, 1);
        p8(IDL8, 8'hFF, 1);
        p8(PRE8, 8'h01, 1);
        p8(64'h07070707FD665544, 8'hF8, 1);
        p8(IDL8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 0);
        send(0, 64'hEEEEEEEEEE332211, 1, 3);
        send(0, 64'hEEEEEEEEEE665544, 1, 3);
        wait_drain();
        check("t2_frame_cnt", 80'(fc8), 80'd3);

        // Underrun on the third data beat: ERR beat, three drain idles, IPG from drain end.
        p8(PRE8, 8'h01, 1);
        p8({8{8'h11}}, 8'h00, 1);
        p8({8{8'h22}}, 8'h00, 1);
        p8(ERR8, 8'hFF, 1);
        for (int i = 0; i < 5; i++) p8(IDL8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 0);
        send(0, {8{8'h11}}, 0, 8);
        send(0, {8{8'h22}}, 0, 8);
        @(posedge clk);
        #1;
        send(0, {8{8'h33}}, 0, 8);
        send(0, {8{8'h44}}, 0, 8);
        send(0, {8{8'h55}}, 1, 8);
        wait_drain();
        check("t4_underrun_cnt", 80'(uc8), 80'd1);
        check("t4_frame_cnt",    80'(fc8), 80'd3);

        // 4 lanes: two preamble beats, full last beat -> TERM tail, 3 IPG beats, back-to-back start.
        p4(32'h555555FB, 4'h1, 1);
        p4(32'hD5555555, 4'h0, 1);
        p4(32'h44332211, 4'h0, 1);
        p4(32'h88776655, 4'h0, 1);
        p4(32'h070707FD, 4'hF, 1);
        for (int i = 0; i < 3; i++) p4(IDL4, 4'hF, 1);
        p4(32'h555555FB, 4'h1, 1);
        p4(32'hD5555555, 4'h0, 1);
        p4(32'h07FDBBAA, 4'hC, 1);
        for (int i = 0; i < 3; i++) p4(IDL4, 4'hF, 1);
        p4(IDL4, 4'hF, 0);
        send(1, 64'h44332211, 0, 4);
        send(1, 64'h88776655, 1, 4);
        send(1, 64'hEEEEBBAA, 1, 2);
        wait_drain();
        check("t3_frame_cnt4",    80'(fc4), 80'd2);
        check("t3_underrun_cnt4", 80'(uc4), 80'd0);

        // Reset in the middle of DATA: everything returns to idle at once.
        send(0, {8{8'h66}}, 0, 8);
        send(0, {8{8'h77}}, 0, 8);
        check("t5_busy_before", 80'({b8, r8}), 80'({1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 80'({mc8, md8}), 80'({8'hFF, IDL8}));
        check("t5_rst_misc", 80'({r8, b8, fc8, uc8}), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // nbytes 0 and nbytes > LANES both behave as a full last beat.
        p8(PRE8, 8'h01, 1);
        p8(64'h0807060504030201, 8'h00, 1);
        p8(TRM8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 0);
        send(0, 64'h0807060504030201, 1, 0);
        wait_drain();
        p8(PRE8, 8'h01, 1);
        p8(64'h1817161514131211, 8'h00, 1);
        p8(TRM8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 1);
        p8(IDL8, 8'hFF, 0);
        send(0, 64'h1817161514131211, 1, 12);
        wait_drain();
        check("t7_frame_cnt", 80'(fc8), 80'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
